irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 24 ++
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and a small one-hot helper.
package irq_ctrl_pkg;

    localparam int IRQ_W = 8;

    localparam logic [3:0] ADDR_MASK    = 4'd0;
    localparam logic [3:0] ADDR_EDGE    = 4'd1;
    localparam logic [3:0] ADDR_PENDING = 4'd2;
    localparam logic [3:0] ADDR_VBASE   = 4'd3;
    localparam logic [3:0] ADDR_INSERV  = 4'd4;
    localparam logic [3:0] ADDR_EOI     = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [IRQ_W-1:0] onehot8(input logic [2:0] idx);
        return IRQ_W'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// 8-to-3 priority encoder; the lowest set index wins, valid flags any request.
module irq_prio_enc (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       valid
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised sources, edge/level pending capture,
// single-level request/acknowledge/EOI handshake with a vectored grant.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               wb_clk_i,
    input  logic               rst,
    input  logic [3:0]         addr,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    input  logic               bus_cyc,
    input  logic               bus_we,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_ack,
    output logic               int_req,
    output logic [7:0]         int_vec,
    output irq_state_e         fsm_state
);

    // Handshake: int_req is high exactly while the FSM sits in REQ; an int_ack
    // pulse is honoured only in that state and drops int_req on the next edge.

    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;
    logic [NUM_IRQ-1:0] sync_d;
    logic [NUM_IRQ-1:0] mask_r;
    logic [NUM_IRQ-1:0] edge_r;
    logic [NUM_IRQ-1:0] pend_r;
    logic [NUM_IRQ-1:0] inserv_r;
    logic [4:0]         vbase_r;
    irq_state_e         state_r;

    logic               bus_wr;
    logic               eoi;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] grant_clr;
    logic [NUM_IRQ-1:0] pend_next;
    logic [2:0]         win_idx;
    logic               win_valid;
    logic               grant;

    assign bus_wr    = bus_cyc & bus_we;
    assign eoi       = bus_wr && (addr == ADDR_EOI);
    assign rise      = sync2 & ~sync_d;
    assign active    = pend_r & mask_r;
    assign fsm_state = state_r;

    irq_prio_enc u_prio (
        .req   (active),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign grant = (state_r == ST_REQ) && win_valid && int_ack;

    always_comb begin
        w1c       = '0;
        grant_clr = '0;
        if (bus_wr && (addr == ADDR_PENDING)) begin
            w1c = data_in;
        end
        if (grant) begin
            grant_clr = onehot8(win_idx) & edge_r;
        end
        // A fresh edge beats any clear in the same cycle; level bits track the input.
        pend_next = (edge_r & (rise | (pend_r & ~w1c & ~grant_clr)))
                  | (~edge_r & sync2);
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            sync_d <= '0;
            pend_r <= '0;
        end else begin
            sync1  <= irq_in;
            sync2  <= sync1;
            sync_d <= sync2;
            pend_r <= pend_next;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            mask_r  <= '0;
            edge_r  <= '1;
            vbase_r <= '0;
        end else if (bus_wr) begin
            case (addr)
                ADDR_MASK:  mask_r  <= data_in;
                ADDR_EDGE:  edge_r  <= data_in;
                ADDR_VBASE: vbase_r <= data_in[7:3];
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            data_out <= 8'h00;
        end else if (bus_cyc) begin
            case (addr)
                ADDR_MASK:    data_out <= mask_r;
                ADDR_EDGE:    data_out <= edge_r;
                ADDR_PENDING: data_out <= pend_r;
                ADDR_VBASE:   data_out <= {vbase_r, 3'b000};
                ADDR_INSERV:  data_out <= inserv_r;
                default:      data_out <= 8'h00;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            int_req  <= 1'b0;
            int_vec  <= 8'h00;
            inserv_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_r <= ST_REQ;
                        int_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!win_valid) begin
                        state_r <= ST_IDLE;
                        int_req <= 1'b0;
                    end else if (int_ack) begin
                        state_r  <= ST_SERVICE;
                        int_req  <= 1'b0;
                        int_vec  <= {vbase_r, win_idx};
                        inserv_r <= onehot8(win_idx);
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        state_r  <= ST_IDLE;
                        inserv_r <= '0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
